// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU memory stage (master) and the data
// memory responder (slave).
interface data_mem_responder_if #(
  parameter int ADDRESS_WIDTH = 32
);
  // A transfer on either channel happens on a rising edge where valid and
  // ready are both high. The sender holds valid and its payload stable until
  // that edge, and valid never waits on ready.
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [31:0]              req_wdata;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering load/store requests after a fixed
// latency, with byte/half/word sizing, load extension and alignment errors.
module data_mem_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int LATENCY       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  data_mem_responder_if.slave        io_mem,
  output logic [1:0]                 o_dbg_state
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      r_state, w_next_state;
  logic [3:0]  r_count, w_next_count;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_rsp_hs;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lo;
  logic             w_err;
  logic [31:0]      w_word;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load;
  logic [31:0]      w_rsp_data;
  logic [3:0]       w_lane_en;
  logic [3:0]       w_lane_we;
  logic [31:0]      w_wdata_lanes;
  logic             w_unused_addr;

  assign w_accept = (r_state == S_IDLE) && io_mem.req_valid && !rst;
  assign w_rsp_hs = (r_state == S_RESP) && io_mem.rsp_ready;
  assign w_idx    = io_mem.req_addr[IDX_W+1:2];
  assign w_lo     = io_mem.req_addr[1:0];
  assign w_word   = r_mem[w_idx];
  // Addresses wrap modulo the memory size; the high bits are deliberately dropped.
  assign w_unused_addr = ^io_mem.req_addr[ADDRESS_WIDTH-1:IDX_W+2];

  always_comb begin
    w_err = 1'b0;
    case (io_mem.req_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = w_lo[0];
      2'b10:   w_err = |w_lo;
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_byte = w_word[7:0];
    case (w_lo)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = w_lo[1] ? w_word[31:16] : w_word[15:0];
    case (io_mem.req_size)
      2'b00:   w_load = io_mem.req_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = io_mem.req_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
    w_rsp_data = (io_mem.req_we || w_err) ? 32'd0 : w_load;
  end

  // Store data is replicated across lanes so each enabled lane picks up the LSBs.
  always_comb begin
    w_lane_en     = 4'b0000;
    w_wdata_lanes = io_mem.req_wdata;
    case (io_mem.req_size)
      2'b00: begin
        w_lane_en     = 4'b0001 << w_lo;
        w_wdata_lanes = {4{io_mem.req_wdata[7:0]}};
      end
      2'b01: begin
        w_lane_en     = w_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata_lanes = {2{io_mem.req_wdata[15:0]}};
      end
      2'b10:   w_lane_en = 4'b1111;
      default: w_lane_en = 4'b0000;
    endcase
    w_lane_we = (w_accept && io_mem.req_we && !w_err) ? w_lane_en : 4'b0000;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_lane_we[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY > 1) begin
            w_next_state = S_WAIT;
            w_next_count = LAT_M1;
          end else begin
            w_next_state = S_RESP;
          end
        end
      end
      S_WAIT: begin
        w_next_count = r_count - 4'd1;
        if (r_count == 4'd1) w_next_state = S_RESP;
      end
      S_RESP: begin
        if (w_rsp_hs) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      if (w_accept) begin
        r_rdata <= w_rsp_data;
        r_err   <= w_err;
      end else if (w_rsp_hs) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  assign io_mem.req_ready = (r_state == S_IDLE) && !rst;
  assign io_mem.rsp_valid = (r_state == S_RESP);
  assign io_mem.rsp_rdata = r_rdata;
  assign io_mem.rsp_err   = r_err;
  assign o_dbg_state      = r_state;
endmodule
